// File: rtl/word_scramble_engine_if.sv
// Word-play handshake between the game controller and the scramble engine.
//   master : controller side. Drives lettNum, targetWord, scramPls, flipPls,
//            indIn1 and indIn2; observes the engine's outputs.
//   slave  : engine side. Drives dispWord, isCorrect, busy, swapCount and
//            badSwap.
interface word_scramble_engine_if #(
    parameter int LETTER_W = 5,
    parameter int MAX_LEN  = 6
);
    localparam int WORD_W = LETTER_W * MAX_LEN;

    logic [1:0]        lettNum;
    logic [WORD_W-1:0] targetWord;
    logic              scramPls;
    logic              flipPls;
    logic [2:0]        indIn1;
    logic [2:0]        indIn2;
    logic [WORD_W-1:0] dispWord;
    logic              isCorrect;
    logic              busy;
    logic [7:0]        swapCount;
    logic              badSwap;

    modport master (
        output lettNum, targetWord, scramPls, flipPls, indIn1, indIn2,
        input  dispWord, isCorrect, busy, swapCount, badSwap
    );

    modport slave (
        input  lettNum, targetWord, scramPls, flipPls, indIn1, indIn2,
        output dispWord, isCorrect, busy, swapCount, badSwap
    );
endinterface

// File: rtl/word_scramble_engine.sv
// Word scramble engine: latches a target word, shuffles it with LFSR-driven
// swaps, then applies player swaps and pulses isCorrect when the displayed
// word matches the target again.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   wsBus : slave side of the word-play handshake (see word_scramble_engine_if)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no word loaded; waits for scramPls
// SCRAMBLE | one LFSR-picked swap per cycle for SCRAM_ROUNDS cycles
// FIX      | rotates the word once if the shuffle landed on the target
// READY    | word on display; accepts player flips or a new scramble
// CHECK    | compares the displayed word against the target
module word_scramble_engine #(
    parameter int LETTER_W     = 5,
    parameter int MAX_LEN      = 6,
    parameter int SCRAM_ROUNDS = 8
) (
    input logic                   clk,
    input logic                   rst,
    word_scramble_engine_if.slave wsBus
);
    localparam int WORD_W  = LETTER_W * MAX_LEN;
    localparam int ROUND_W = $clog2(SCRAM_ROUNDS + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCRAMBLE = 3'd1,
        FIX      = 3'd2,
        READY    = 3'd3,
        CHECK    = 3'd4
    } state_t;

    state_t             state, stateNext;
    logic [7:0]         lfsr;
    logic [WORD_W-1:0]  dispReg, dispNext;
    logic [WORD_W-1:0]  targetReg, targetNext;
    logic [2:0]         lenReg, lenNext;
    logic [ROUND_W-1:0] roundCnt, roundNext;
    logic [7:0]         swapReg, swapNext;
    logic               correctReg, correctNext;
    logic               badReg, badNext;

    logic [2:0]         lenSel;
    logic [WORD_W-1:0]  maskedTarget;
    logic [2:0]         pickA, pickB;
    logic               flipValid;

    // Exchange two letter slots; built from constant slices so every index
    // pair maps to a fixed mux leg.
    function automatic logic [WORD_W-1:0] swapSlots(
        input logic [WORD_W-1:0] w,
        input logic [2:0]        i,
        input logic [2:0]        j
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int k = 0; k < MAX_LEN; k++) begin
            for (int m = 0; m < MAX_LEN; m++) begin
                if ((3'(k) == i) && (3'(m) == j)) begin
                    r[k*LETTER_W +: LETTER_W] = w[m*LETTER_W +: LETTER_W];
                    r[m*LETTER_W +: LETTER_W] = w[k*LETTER_W +: LETTER_W];
                end
            end
        end
        return r;
    endfunction

    // Rotate the active slots left by one letter; inactive slots untouched.
    function automatic logic [WORD_W-1:0] rotateActive(
        input logic [WORD_W-1:0] w,
        input logic [2:0]        len
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int k = 0; k < MAX_LEN - 1; k++) begin
            if (3'(k) < (len - 3'd1)) begin
                r[k*LETTER_W +: LETTER_W] = w[(k+1)*LETTER_W +: LETTER_W];
            end
        end
        for (int k = 0; k < MAX_LEN; k++) begin
            if (3'(k) == (len - 3'd1)) begin
                r[k*LETTER_W +: LETTER_W] = w[LETTER_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] maskInactive(
        input logic [WORD_W-1:0] w,
        input logic [2:0]        len
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (3'(k) >= len) begin
                r[k*LETTER_W +: LETTER_W] = '0;
            end
        end
        return r;
    endfunction

    // lettNum = 3 is treated like 2 (six letters).
    assign lenSel = (wsBus.lettNum == 2'd3) ? 3'd6 : (3'd4 + {1'b0, wsBus.lettNum});

    // The target is stored masked as well, so ROM garbage above the active
    // length can never stop the full-width compare from matching.
    assign maskedTarget = maskInactive(wsBus.targetWord, lenSel);

    // len >= 4, so one subtraction brings any 3-bit pick into range.
    assign pickA = (lfsr[2:0] >= lenReg) ? (lfsr[2:0] - lenReg) : lfsr[2:0];
    assign pickB = (lfsr[5:3] >= lenReg) ? (lfsr[5:3] - lenReg) : lfsr[5:3];

    assign flipValid = (wsBus.indIn1 < lenReg) && (wsBus.indIn2 < lenReg) &&
                       (wsBus.indIn1 != wsBus.indIn2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        dispNext    = dispReg;
        targetNext  = targetReg;
        lenNext     = lenReg;
        roundNext   = roundCnt;
        swapNext    = swapReg;
        correctNext = 1'b0;
        badNext     = 1'b0;

        unique case (state)
            IDLE, READY: begin
                if (wsBus.scramPls) begin
                    targetNext = maskedTarget;
                    lenNext    = lenSel;
                    dispNext   = maskedTarget;
                    swapNext   = 8'd0;
                    roundNext  = '0;
                    stateNext  = SCRAMBLE;
                end else if ((state == READY) && wsBus.flipPls) begin
                    if (flipValid) begin
                        dispNext  = swapSlots(dispReg, wsBus.indIn1, wsBus.indIn2);
                        swapNext  = (swapReg == 8'hFF) ? swapReg : (swapReg + 8'd1);
                        stateNext = CHECK;
                    end else begin
                        badNext = 1'b1;
                    end
                end
            end
            SCRAMBLE: begin
                dispNext  = swapSlots(dispReg, pickA, pickB);
                roundNext = roundCnt + ROUND_W'(1);
                if (roundCnt == ROUND_W'(SCRAM_ROUNDS - 1)) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                // A single rotation breaks any match except an all-same word.
                if (dispReg == targetReg) begin
                    dispNext = rotateActive(dispReg, lenReg);
                end
                stateNext = READY;
            end
            CHECK: begin
                correctNext = (dispReg == targetReg);
                stateNext   = READY;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Taps x^8+x^6+x^5+x^4+1; free-running in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr       <= 8'hA5;
            dispReg    <= '0;
            targetReg  <= '0;
            lenReg     <= 3'd4;
            roundCnt   <= '0;
            swapReg    <= 8'd0;
            correctReg <= 1'b0;
            badReg     <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            dispReg    <= dispNext;
            targetReg  <= targetNext;
            lenReg     <= lenNext;
            roundCnt   <= roundNext;
            swapReg    <= swapNext;
            correctReg <= correctNext;
            badReg     <= badNext;
        end
    end

    assign wsBus.dispWord  = dispReg;
    assign wsBus.isCorrect = correctReg;
    assign wsBus.busy      = (state == SCRAMBLE) || (state == FIX);
    assign wsBus.swapCount = swapReg;
    assign wsBus.badSwap   = badReg;
endmodule

// File: doc/word_scramble_engine.md
# word_scramble_engine

Responder to the game controller's word-play handshake. On a scramble pulse it latches the target word, shuffles it with LFSR-driven swaps, and presents the scrambled word for display. It then applies each player-requested letter swap (flip pulse plus two indices) and returns a one-cycle `isCorrect` pulse when the displayed word again matches the target. It sits between the controller, the word ROM and the display driver.

## Interface
Parameters:
- `LETTER_W`, 5: bits per letter code, 1..26 = A..Z, 0 = blank.
- `MAX_LEN`, 6: letter slots in the word buffer.
- `SCRAM_ROUNDS`, 8: random swaps performed per scramble.

Ports (clock and reset first):
- `clk`, in, 1: system clock, all state on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `lettNum`, in, 2: word-length select; length = 4 + `lettNum`; values 0..2 are legal, and 3 is treated as 2.
- `targetWord`, in, 30: letters from the ROM; slot i is at bits [5i+4:5i].
- `scramPls`, in, 1: start scramble; latches `targetWord` and `lettNum`.
- `flipPls`, in, 1: request a swap of slots `indIn1` and `indIn2`.
- `indIn1`, in, 3: first swap index.
- `indIn2`, in, 3: second swap index.
- `dispWord`, out, 30: current scrambled word.
- `isCorrect`, out, 1: one-cycle pulse when `dispWord` equals the latched target.
- `busy`, out, 1: high while scrambling.
- `swapCount`, out, 8: number of accepted player swaps, saturating.
- `badSwap`, out, 1: one-cycle pulse when a flip request is rejected.

## Operation
- **States:** IDLE, SCRAMBLE, FIX, READY, CHECK.
- **Reset values:** state IDLE, all outputs 0, LFSR = 8'hA5.
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle in every state, so player timing seeds the randomness.
- **Index picking:** index a = LFSR[2:0], b = LFSR[5:3]. If either is ≥ len, subtract len (this always lands in range, since len ≥ 4).
- **IDLE or READY + `scramPls`:**
  - Latch target and len into internal registers; copy the target into `dispWord` with slots ≥ len forced to 0.
  - Clear `swapCount`; go to SCRAMBLE with the round counter at 0.
- **SCRAMBLE:**
  - Each cycle, swap slots a and b of `dispWord` (a == b is a no-op).
  - After SCRAM_ROUNDS swaps, go to FIX.
- **FIX:**
  - If `dispWord` equals the target, rotate the active slots left by one letter: slot i takes slot i+1, and slot len-1 takes slot 0.
  - Go to READY. A word whose letters are all identical stays equal; this is accepted.
- **READY + `flipPls`:** a request is valid when `indIn1` < len, `indIn2` < len, and `indIn1` ≠ `indIn2`.
  - Valid: swap the two slots, increment `swapCount` (saturating at 255), go to CHECK.
  - Invalid: pulse `badSwap`, leave the word unchanged, stay in READY.
- **CHECK:** compare the full 30-bit `dispWord` with the target. Pulse `isCorrect` if equal, then return to READY.
- **Priority in READY:** `scramPls` beats `flipPls` when both are asserted in the same cycle.
- **Ignored inputs:**
  - `flipPls` and `scramPls` are ignored while `busy` (SCRAMBLE, FIX) and in CHECK.
  - `flipPls` is ignored in IDLE.
- **Length latching:** `lettNum` and `targetWord` are sampled only on an accepted `scramPls`. Later changes have no effect.
- **Asynchronous reset:** reset asserted mid-operation returns to the reset values immediately. A partially scrambled word is discarded.

## Timing
- `busy` rises the cycle after `scramPls` is accepted and stays high for SCRAM_ROUNDS + 1 cycles (SCRAMBLE plus FIX).
- READY is entered on the following edge.
- Swap latency: `dispWord` updates one cycle after `flipPls` is sampled.
- `isCorrect`: high for exactly one cycle, two cycles after `flipPls` is sampled.
- The next flip can be accepted the cycle after CHECK, i.e. at most one swap every 2 cycles.
- `badSwap`: pulses one cycle after an invalid `flipPls`.

## Test plan
- **Reset:** assert `rst` = 0 mid-SCRAMBLE -> `dispWord` = 0, `busy` = 0, `isCorrect` = 0, `swapCount` = 0 immediately; after release, a `scramPls` is needed before any swap is accepted.
- **Scramble, 4 letters:** target "GAME" = {5,13,1,7}, `lettNum` = 0, pulse `scramPls` ->
  - `busy` high for 9 cycles;
  - final `dispWord` ≠ target, is a permutation of {7,1,13,5}, and bits [29:20] = 0.
- **Solve:** from a known scramble, apply the inverse swaps with legal indices ->
  - `isCorrect` pulses exactly once, 2 cycles after the final `flipPls`;
  - `swapCount` equals the number of swaps applied.
- **Bad indices** with len = 5 (`lettNum` = 1):
  - `indIn1` = 5, `indIn2` = 2 -> `badSwap` pulse, word unchanged;
  - `indIn1` = 3, `indIn2` = 3 -> `badSwap` pulse;
  - `swapCount` unchanged.
- **Collisions:**
  - `flipPls` during `busy` -> ignored;
  - `scramPls` and `flipPls` in the same cycle in READY -> re-scramble, no swap, `swapCount` = 0.
- **All-same word** "AAAAAA", `lettNum` = 2 -> scramble completes, and the first legal swap yields an `isCorrect` pulse.
